// File: rtl/gpr_wb_arbiter.sv
// Write-port arbiter for the GPR file: pipeline writeback (port 0) vs. mul/div results (port 1),
// with a busy scoreboard for outstanding mul/div destinations and a starvation guard for port 1.
module gpr_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_valid,
  input  logic [4:0]  p0_addr,
  input  logic [31:0] p0_data,
  input  logic        p0_of_en,
  input  logic        p0_of_flag,
  output logic        p0_ready,
  input  logic        p1_valid,
  input  logic [4:0]  p1_addr,
  input  logic [31:0] p1_data,
  output logic        p1_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_addr,
  output logic        iss_ready,
  input  logic [4:0]  chk_addr1,
  input  logic [4:0]  chk_addr2,
  output logic        chk_busy,
  output logic        gpr_wr_en,
  output logic [4:0]  gpr_wr_addr,
  output logic [31:0] gpr_wr_data,
  output logic        gpr_of_wr_en,
  output logic        gpr_of_flag
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  logic [31:0] busy_q, busy_d;
  logic [3:0]  wait_q, wait_d;
  logic        wr_en_q;
  logic [4:0]  wr_addr_q;
  logic [31:0] wr_data_q;
  logic        of_wr_en_q;
  logic        of_flag_q;

  logic p0_elig;
  logic starve;
  logic iss_fire;

  assign iss_ready = !busy_q[iss_addr];
  assign chk_busy  = busy_q[chk_addr1] | busy_q[chk_addr2];
  assign p0_elig   = p0_valid && !busy_q[p0_addr];
  assign starve    = (wait_q >= STARVE_LIM);
  assign iss_fire  = iss_valid && iss_ready && (iss_addr != 5'd0);

  always_comb begin
    p0_ready = 1'b0;
    p1_ready = 1'b0;
    if (starve && p1_valid) begin
      p1_ready = 1'b1;
    end else if (p0_elig) begin
      p0_ready = 1'b1;
    end else begin
      p1_ready = p1_valid;
    end
  end

  // Per-register scoreboard update; a same-cycle issue beats the port-1 clear.
  assign busy_d[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_busy
      logic set_bit;
      logic clr_bit;
      assign set_bit    = iss_fire && (iss_addr == 5'(gi));
      assign clr_bit    = p1_ready && (p1_addr == 5'(gi));
      assign busy_d[gi] = set_bit || (busy_q[gi] && !clr_bit);
    end
  endgenerate

  always_comb begin
    wait_d = wait_q;
    if (!p1_valid || p1_ready) begin
      wait_d = 4'd0;
    end else if (wait_q != 4'hF) begin
      wait_d = wait_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q     <= '0;
      wait_q     <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      of_wr_en_q <= 1'b0;
      of_flag_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      wait_q <= wait_d;
      if (p0_ready) begin
        // An overflowing op updates only the flag, not its destination register.
        wr_en_q    <= (p0_addr != 5'd0) && !(p0_of_en && p0_of_flag);
        wr_addr_q  <= p0_addr;
        wr_data_q  <= p0_data;
        of_wr_en_q <= p0_of_en;
        of_flag_q  <= p0_of_flag;
      end else if (p1_ready) begin
        wr_en_q    <= (p1_addr != 5'd0);
        wr_addr_q  <= p1_addr;
        wr_data_q  <= p1_data;
        of_wr_en_q <= 1'b0;
      end else begin
        wr_en_q    <= 1'b0;
        of_wr_en_q <= 1'b0;
      end
    end
  end

  assign gpr_wr_en    = wr_en_q;
  assign gpr_wr_addr  = wr_addr_q;
  assign gpr_wr_data  = wr_data_q;
  assign gpr_of_wr_en = of_wr_en_q;
  assign gpr_of_flag  = of_flag_q;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Directed bench for gpr_wb_arbiter: reset, writeback, WAW hold-off, starvation,
// overflow-flag writes and issue/clear collision with reset.
module tb_gpr_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_valid;
  logic [4:0]  p0_addr;
  logic [31:0] p0_data;
  logic        p0_of_en;
  logic        p0_of_flag;
  logic        p0_ready;
  logic        p1_valid;
  logic [4:0]  p1_addr;
  logic [31:0] p1_data;
  logic        p1_ready;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        iss_ready;
  logic [4:0]  chk_addr1;
  logic [4:0]  chk_addr2;
  logic        chk_busy;
  logic        gpr_wr_en;
  logic [4:0]  gpr_wr_addr;
  logic [31:0] gpr_wr_data;
  logic        gpr_of_wr_en;
  logic        gpr_of_flag;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gpr_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_data(p0_data),
    .p0_of_en(p0_of_en), .p0_of_flag(p0_of_flag), .p0_ready(p0_ready),
    .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_data(p1_data), .p1_ready(p1_ready),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .chk_busy(chk_busy),
    .gpr_wr_en(gpr_wr_en), .gpr_wr_addr(gpr_wr_addr), .gpr_wr_data(gpr_wr_data),
    .gpr_of_wr_en(gpr_of_wr_en), .gpr_of_flag(gpr_of_flag)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) begin
      $display("ok   %s = %0h", tag, obs);
    end else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; p0_valid = 1'b0; p0_addr = '0; p0_data = '0; p0_of_en = 1'b0; p0_of_flag = 1'b0;
    p1_valid = 1'b0; p1_addr = '0; p1_data = '0; iss_valid = 1'b0; iss_addr = '0;
    chk_addr1 = 5'd8; chk_addr2 = 5'd31;
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rst_wr_en", 32'(gpr_wr_en), 0);
    chk("rst_of_wr_en", 32'(gpr_of_wr_en), 0);
    chk("rst_of_flag", 32'(gpr_of_flag), 0);
    chk("rst_addr", 32'(gpr_wr_addr), 0);
    chk("rst_data", gpr_wr_data, 0);
    chk("idle_p0_ready", 32'(p0_ready), 0);
    chk("idle_p1_ready", 32'(p1_ready), 0);
    chk("idle_chk_busy", 32'(chk_busy), 0);

    // Plain port-0 write to r5
    p0_valid = 1'b1; p0_addr = 5'd5; p0_data = 32'h1234;
    #1;
    chk("a_p0_ready", 32'(p0_ready), 1);
    chk("a_p1_ready", 32'(p1_ready), 0);
    tick();
    p0_valid = 1'b0;
    #1;
    chk("a_wr_en", 32'(gpr_wr_en), 1);
    chk("a_addr", 32'(gpr_wr_addr), 5);
    chk("a_data", gpr_wr_data, 32'h1234);
    chk("a_of_wr_en", 32'(gpr_of_wr_en), 0);
    tick();
    chk("a_wr_en_drop", 32'(gpr_wr_en), 0);
    chk("a_addr_hold", 32'(gpr_wr_addr), 5);

    // Issue to r8, p0 to r8 held off until p1 result for r8 retires
    iss_valid = 1'b1; iss_addr = 5'd8;
    #1;
    chk("b_iss_ready", 32'(iss_ready), 1);
    tick();
    iss_valid = 1'b0;
    p0_valid = 1'b1; p0_addr = 5'd8; p0_data = 32'h5555; chk_addr1 = 5'd8; chk_addr2 = 5'd0;
    #1;
    chk("b_p0_blocked", 32'(p0_ready), 0);
    chk("b_chk_busy", 32'(chk_busy), 1);
    chk("b_iss_ready_busy", 32'(iss_ready), 0);
    tick();
    p1_valid = 1'b1; p1_addr = 5'd8; p1_data = 32'hBEEF;
    #1;
    chk("b_p1_ready", 32'(p1_ready), 1);
    chk("b_p0_still_blocked", 32'(p0_ready), 0);
    tick();
    p1_valid = 1'b0;
    #1;
    chk("b_wr1_en", 32'(gpr_wr_en), 1);
    chk("b_wr1_addr", 32'(gpr_wr_addr), 8);
    chk("b_wr1_data", gpr_wr_data, 32'hBEEF);
    chk("b_chk_busy_clear", 32'(chk_busy), 0);
    chk("b_p0_ready_now", 32'(p0_ready), 1);
    tick();
    p0_valid = 1'b0;
    #1;
    chk("b_wr2_en", 32'(gpr_wr_en), 1);
    chk("b_wr2_addr", 32'(gpr_wr_addr), 8);
    chk("b_wr2_data", gpr_wr_data, 32'h5555);

    // Starvation: p0 wins 4 cycles, p1 forced on the 5th
    p0_valid = 1'b1; p0_addr = 5'd3; p0_data = 32'h3333;
    p1_valid = 1'b1; p1_addr = 5'd9; p1_data = 32'h99;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("c_p0_win%0d", i), 32'(p0_ready), 1);
      chk($sformatf("c_p1_wait%0d", i), 32'(p1_ready), 0);
      tick();
    end
    #1;
    chk("c_p1_forced", 32'(p1_ready), 1);
    chk("c_p0_denied", 32'(p0_ready), 0);
    tick();
    #1;
    chk("c_p0_again", 32'(p0_ready), 1);
    chk("c_p1_refused", 32'(p1_ready), 0);
    chk("c_wr_data", gpr_wr_data, 32'h99);
    chk("c_wr_addr", 32'(gpr_wr_addr), 9);
    chk("c_of_wr_en", 32'(gpr_of_wr_en), 0);
    p0_valid = 1'b0; p1_valid = 1'b0;
    tick();

    // Overflow: flag updated, register write suppressed; r0 write suppressed
    p0_valid = 1'b1; p0_addr = 5'd3; p0_data = 32'h77; p0_of_en = 1'b1; p0_of_flag = 1'b1;
    #1;
    chk("d_p0_ready", 32'(p0_ready), 1);
    tick();
    p0_addr = 5'd0; p0_data = 32'h7; p0_of_en = 1'b0; p0_of_flag = 1'b0;
    #1;
    chk("d_of_wr_en_supp", 32'(gpr_wr_en), 0);
    chk("d_of_wr_en", 32'(gpr_of_wr_en), 1);
    chk("d_of_flag", 32'(gpr_of_flag), 1);
    chk("d_of_addr", 32'(gpr_wr_addr), 3);
    tick();
    p0_valid = 1'b0;
    #1;
    chk("d_r0_wr_en", 32'(gpr_wr_en), 0);
    chk("d_r0_of_wr_en", 32'(gpr_of_wr_en), 0);
    chk("d_r0_data", gpr_wr_data, 7);

    // Issue r4 and p1 write r4 in the same cycle: busy stays set; then reset clears it
    iss_valid = 1'b1; iss_addr = 5'd4; p1_valid = 1'b1; p1_addr = 5'd4; p1_data = 32'h44;
    chk_addr1 = 5'd4; chk_addr2 = 5'd0;
    #1;
    chk("e_iss_ready", 32'(iss_ready), 1);
    chk("e_p1_ready", 32'(p1_ready), 1);
    tick();
    iss_valid = 1'b0; p1_valid = 1'b0;
    #1;
    chk("e_busy_kept", 32'(chk_busy), 1);
    chk("e_wr_en", 32'(gpr_wr_en), 1);
    chk("e_wr_data", gpr_wr_data, 32'h44);
    p0_valid = 1'b1; p0_addr = 5'd5; p0_data = 32'hAA; rst_n = 1'b0;
    tick();
    p0_valid = 1'b0; rst_n = 1'b1;
    #1;
    chk("e_rst_busy", 32'(chk_busy), 0);
    chk("e_rst_wr_en", 32'(gpr_wr_en), 0);
    chk("e_rst_addr", 32'(gpr_wr_addr), 0);
    chk("e_rst_data", gpr_wr_data, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Owns the single write port of the general-purpose register file.
- Arbitrates between two requesters: port 0 is the pipeline writeback; port 1 is a long-latency multiply/divide unit.
- Keeps a busy scoreboard of registers with outstanding port-1 results, so the pipeline can detect RAW hazards and WAW ordering is enforced.
- Drives the register file's write enable, address, data and overflow-write controls from registers.

Parameters:
- STARVE_LIMIT, 4, consecutive cycles a valid port-1 request may be refused before it takes priority over port 0 (range 1..15).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- p0_valid  in  1  pipeline writeback request
- p0_addr  in  5  destination register
- p0_data  in  32  write data
- p0_of_en  in  1  request overflow-flag update (bit 0 of r30)
- p0_of_flag  in  1  overflow flag value
- p0_ready  out  1  port-0 request accepted this cycle (combinational)
- p1_valid  in  1  mul/div result request
- p1_addr  in  5  destination register
- p1_data  in  32  result data
- p1_ready  out  1  port-1 request accepted this cycle (combinational)
- iss_valid  in  1  mul/div issue; marks iss_addr busy
- iss_addr  in  5  destination of issued op
- iss_ready  out  1  issue accepted (combinational)
- chk_addr1  in  5  hazard lookup address 1
- chk_addr2  in  5  hazard lookup address 2
- chk_busy  out  1  either lookup address is busy (combinational)
- gpr_wr_en  out  1  to register-file write enable, registered
- gpr_wr_addr  out  5  registered
- gpr_wr_data  out  32  registered
- gpr_of_wr_en  out  1  registered
- gpr_of_flag  out  1  registered

Behaviour:
- Reset (rst_n=0 at a clock edge): busy[31:0]=0, wait counter=0, all gpr_* outputs=0.
  - Reset asserted mid-operation discards every pending busy bit and any in-flight write: outputs are 0 in the cycle after the reset edge.
- Scoreboard: busy[0] is hard-wired to 0.
  - Set: iss_valid && iss_ready && iss_addr!=0 sets busy[iss_addr].
  - Clear: a port-1 acceptance clears busy[p1_addr].
  - Same address set and cleared in the same cycle: set wins.
  - iss_ready = !busy[iss_addr] (iss_addr=0 always ready).
  - chk_busy = busy[chk_addr1] | busy[chk_addr2].
- Eligibility: p0_elig = p0_valid && !busy[p0_addr]. A pipeline write to a pending register is held off to preserve WAW order.
- Starvation: starve = (wait counter >= STARVE_LIMIT).
- Arbitration (combinational, same cycle):
  - If starve && p1_valid: p1_ready=1, p0_ready=0.
  - Else if p0_elig: p0_ready=1, p1_ready=0.
  - Else: p1_ready=p1_valid, p0_ready=0.
  - At most one ready per cycle.
- Wait counter (4 bits, saturating at 15):
  - Cleared on port-1 acceptance or when p1_valid=0.
  - Increments each cycle p1_valid && !p1_ready.
- Write launch: latency 1. A transfer accepted at edge N appears on gpr_* for exactly the cycle after edge N.
  - Port 0: gpr_wr_en = (p0_addr!=0) && !(p0_of_en && p0_of_flag); gpr_of_wr_en = p0_of_en; gpr_of_flag = p0_of_flag; addr/data copied.
  - Port 1: gpr_wr_en = (p1_addr!=0); gpr_of_wr_en = 0.
  - No acceptance: gpr_wr_en=0 and gpr_of_wr_en=0; addr/data hold their previous values.
- Port-1 writeback to a non-busy register is legal. It is written normally and leaves busy unchanged.
- Port 1 is accepted in the same cycle p0 is blocked on the busy register it is about to clear. Port 0 becomes eligible the following cycle.

Test Plan:
- Reset then idle → all gpr_* 0; p0_ready=p1_ready=0; chk_busy=0 for any chk_addr.
- p0 {addr 5, data 0x1234, of_en 0} alone → p0_ready=1; next cycle gpr_wr_en=1, addr 5, data 0x1234; following cycle gpr_wr_en=0.
- Issue to r8, then p0 to r8 → p0_ready=0 and chk_busy=1 (chk_addr1=8); p1 {r8, 0xBEEF} → accepted, busy[8] clears; p0 accepted the next cycle, so the r8 writes occur in order 0xBEEF then p0 data.
- p0 (non-busy register) and p1 valid continuously, STARVE_LIMIT=4 → p0 wins 4 cycles; 5th cycle p1_ready=1 and p0_ready=0; counter back to 0.
- p0 {addr 3, of_en 1, of_flag 1} → next cycle gpr_wr_en=0, gpr_of_wr_en=1, gpr_of_flag=1; p0 {addr 0, data 7} → gpr_wr_en=0.
- Issue r4 and p1 clear of r4 in the same cycle → busy[4] stays 1. rst_n=0 with busy[4]=1 → busy[4]=0 and outputs 0 after the edge.
